matmul_tile_engine: RTL and testbench

- Tiled matmul sequencer and accumulator: computes C[M×COL] = Σ_t A_t[M×ROW]·W_t[ROW×COL] over K tiles.
- Drives weight-load and activation streaming into an external systolic array (sa_compute instance at the top level) and collects the deskewed column results.
- Accumulates across tiles through a dual-port partial-sum buffer and writes the final narrowed rows to the output buffer.
- Successor to the single-tile matrix_mult datapath: adds multi-tile accumulation, a separate accumulator width, and a programmable row count.

---
 rtl/matmul_tile_engine.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_matmul_tile_engine.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_engine.sv
// ---------------------------------------------------------------------------
// matmul_tile_engine
//
// Tiled matrix-multiply sequencer and accumulator. Computes
//   C[M x COL] = sum over t of A_t[M x ROW] * W_t[ROW x COL], t = 0..K-1
// by driving an external systolic array (weight load, then activation
// streaming) and accumulating the array column results across tiles through
// a dual-port partial-sum buffer. The last tile writes narrowed rows to the
// output buffer.
//
// Optional feature macro: SATURATE_EN
//   defined   : narrowing clamps each signed sum to the OUT_WIDTH signed range
//   undefined : narrowing keeps the low OUT_WIDTH bits (two's-complement wrap)
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   start_i                level start, a run begins on a 0->1 edge in IDLE
//   k_tiles_i, m_rows_i    tile count K and row count M, sampled at start
//   busy_o, done_o         run in progress / run complete (held until start low)
//   wb_*                   weight buffer read port (1-cycle latency)
//   ib_*                   activation buffer read port (1-cycle latency)
//   arr_*                  systolic array interface (mode, weights, acts, psums)
//   ps_rd_*, ps_wr_*       partial-sum buffer read and write ports
//   ob_*                   output buffer write port
// ---------------------------------------------------------------------------
module matmul_tile_engine #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 8,
  parameter int ROW       = 4,
  parameter int COL       = 4,
  parameter int ARRAY_LAT = 6,
  parameter int I_SIZE    = 256,
  parameter int W_SIZE    = 256,
  parameter int P_SIZE    = 64,
  parameter int O_SIZE    = 64,
  parameter int MAX_K     = 16,
  parameter int MAX_M     = 64
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                start_i,
  input  logic [$clog2(MAX_K+1)-1:0]          k_tiles_i,
  input  logic [$clog2(MAX_M+1)-1:0]          m_rows_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                wb_cenb_o,
  output logic [$clog2(W_SIZE)-1:0]           wb_addr_o,
  input  logic [COL*WIDTH-1:0]                wb_data_i,
  output logic                                ib_cenb_o,
  output logic [$clog2(I_SIZE)-1:0]           ib_addr_o,
  input  logic [ROW*WIDTH-1:0]                ib_data_i,
  output logic                                arr_mode_o,
  output logic                                arr_wvalid_o,
  output logic [COL*WIDTH-1:0]                arr_weight_o,
  output logic                                arr_avalid_o,
  output logic [ROW*WIDTH-1:0]                arr_act_o,
  input  logic [COL*ACC_WIDTH-1:0]            arr_psum_i,
  output logic                                ps_rd_cenb_o,
  output logic [$clog2(P_SIZE)-1:0]           ps_rd_addr_o,
  input  logic [COL*ACC_WIDTH-1:0]            ps_rd_data_i,
  output logic                                ps_wr_cenb_o,
  output logic [$clog2(P_SIZE)-1:0]           ps_wr_addr_o,
  output logic [COL*ACC_WIDTH-1:0]            ps_wr_data_o,
  output logic                                ob_cenb_o,
  output logic [$clog2(O_SIZE)-1:0]           ob_addr_o,
  output logic [COL*OUT_WIDTH-1:0]            ob_data_o
);

  localparam int KW   = $clog2(MAX_K+1);
  localparam int MW   = $clog2(MAX_M+1);
  localparam int WAW  = $clog2(W_SIZE);
  localparam int IAW  = $clog2(I_SIZE);
  localparam int PAW  = $clog2(P_SIZE);
  localparam int OAW  = $clog2(O_SIZE);
  localparam int CMAX = (ROW > MAX_M) ? ROW : MAX_M;
  localparam int CW   = $clog2(CMAX+1);
  localparam int LAT  = ARRAY_LAT;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic            start_prev_q, start_prev_d;
  logic [KW-1:0]   k_q, k_d;
  logic [MW-1:0]   m_q, m_d;
  logic [KW-1:0]   t_q, t_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wvalid_q, wvalid_d;
  logic            avalid_q, avalid_d;
  logic [MW-1:0]   act_m_q, act_m_d;
  logic            mode_q, mode_d;

  logic [LAT-1:0]  pipe_valid_q, pipe_valid_d;
  logic [LAT-1:0]  pipe_first_q, pipe_first_d;
  logic [LAT-1:0]  pipe_last_q, pipe_last_d;
  logic [MW-1:0]   pipe_m_q [LAT];
  logic [MW-1:0]   pipe_m_d [LAT];

  logic [COL*ACC_WIDTH-1:0] sum_q, sum_d;
  logic            wr_valid_q, wr_valid_d;
  logic            wr_last_q, wr_last_d;
  logic [MW-1:0]   wr_m_q, wr_m_d;

  logic start_edge;
  logic last_load;
  logic last_stream;
  logic pipe_empty;
  logic more_tiles;
  logic ib_rd;
  logic ps_rd;
  logic ps_wr;
  logic ob_wr;
  logic [COL*OUT_WIDTH-1:0] ob_narrow;

  // The write stage is deliberately left out of the emptiness test, so the
  // last output row is written in the same cycle the FSM leaves DRAIN.
  assign start_edge  = start_i & ~start_prev_q;
  assign last_load   = (cnt_q == CW'(ROW-1));
  assign last_stream = (cnt_q == CW'(m_q));
  assign pipe_empty  = ~avalid_q & ~(|pipe_valid_q);
  assign more_tiles  = ((t_q + KW'(1)) < k_q);

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. STREAM spends its first cycle idle so the first
  // activation read follows the last weight beat into the array.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          if ((k_tiles_i == '0) || (m_rows_i == '0)) state_d = DONE;
          else                                       state_d = LOAD_W;
        end
      end
      LOAD_W: if (last_load)   state_d = STREAM;
      STREAM: if (last_stream) state_d = DRAIN;
      DRAIN: begin
        if (pipe_empty) state_d = more_tiles ? LOAD_W : DONE;
      end
      DONE:   if (!start_i)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer counters and array-side valid flags.
  always_comb begin
    start_prev_d = start_i;
    k_d      = k_q;
    m_d      = m_q;
    t_d      = t_q;
    cnt_d    = cnt_q;
    wvalid_d = 1'b0;
    avalid_d = 1'b0;
    act_m_d  = act_m_q;
    mode_d   = mode_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        mode_d = 1'b0;
        if (start_edge) begin
          k_d = k_tiles_i;
          m_d = m_rows_i;
          t_d = '0;
        end
      end
      LOAD_W: begin
        mode_d   = 1'b0;
        wvalid_d = 1'b1;
        cnt_d    = last_load ? '0 : cnt_q + CW'(1);
      end
      STREAM: begin
        cnt_d = last_stream ? '0 : cnt_q + CW'(1);
        if (cnt_q != '0) begin
          avalid_d = 1'b1;
          act_m_d  = MW'(cnt_q - CW'(1));
          mode_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (pipe_empty && more_tiles) t_d = t_q + KW'(1);
      end
      DONE: mode_d = 1'b0;
      default: ;
    endcase
  end

  // Latency pipe: one entry per streamed row, aligned so that the last
  // stage coincides with that row's result on arr_psum_i.
  always_comb begin
    pipe_valid_d = {pipe_valid_q[LAT-2:0], avalid_q};
    pipe_first_d = {pipe_first_q[LAT-2:0], (t_q == '0)};
    pipe_last_d  = {pipe_last_q[LAT-2:0], (t_q == (k_q - KW'(1)))};
    pipe_m_d[0]  = act_m_q;
    for (int i = 1; i < LAT; i++) begin
      pipe_m_d[i] = pipe_m_q[i-1];
    end
  end

  // Accumulate: the first tile starts from zero, later tiles add the
  // partial sum fetched one cycle earlier.
  always_comb begin
    sum_d = sum_q;
    if (pipe_valid_q[LAT-1]) begin
      for (int c = 0; c < COL; c++) begin
        sum_d[c*ACC_WIDTH +: ACC_WIDTH] = arr_psum_i[c*ACC_WIDTH +: ACC_WIDTH] +
          (pipe_first_q[LAT-1] ? '0 : ps_rd_data_i[c*ACC_WIDTH +: ACC_WIDTH]);
      end
    end
    wr_valid_d = pipe_valid_q[LAT-1];
    wr_last_d  = pipe_last_q[LAT-1];
    wr_m_d     = pipe_m_q[LAT-1];
  end

  // Start is seen as already high out of reset, so a start level held
  // through reset cannot launch a run by itself.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      start_prev_q <= 1'b1;
      k_q          <= '0;
      m_q          <= '0;
      t_q          <= '0;
      cnt_q        <= '0;
      wvalid_q     <= 1'b0;
      avalid_q     <= 1'b0;
      act_m_q      <= '0;
      mode_q       <= 1'b0;
      pipe_valid_q <= '0;
      pipe_first_q <= '0;
      pipe_last_q  <= '0;
      for (int i = 0; i < LAT; i++) pipe_m_q[i] <= '0;
      sum_q        <= '0;
      wr_valid_q   <= 1'b0;
      wr_last_q    <= 1'b0;
      wr_m_q       <= '0;
    end else begin
      start_prev_q <= start_prev_d;
      k_q          <= k_d;
      m_q          <= m_d;
      t_q          <= t_d;
      cnt_q        <= cnt_d;
      wvalid_q     <= wvalid_d;
      avalid_q     <= avalid_d;
      act_m_q      <= act_m_d;
      mode_q       <= mode_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_first_q <= pipe_first_d;
      pipe_last_q  <= pipe_last_d;
      for (int i = 0; i < LAT; i++) pipe_m_q[i] <= pipe_m_d[i];
      sum_q        <= sum_d;
      wr_valid_q   <= wr_valid_d;
      wr_last_q    <= wr_last_d;
      wr_m_q       <= wr_m_d;
    end
  end

  // Narrow each accumulated column to the output element width.
`ifdef SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2**(OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  always_comb begin
    logic signed [ACC_WIDTH-1:0] elem;
    ob_narrow = '0;
    for (int c = 0; c < COL; c++) begin
      elem = $signed(sum_q[c*ACC_WIDTH +: ACC_WIDTH]);
      if (elem > SAT_MAX)      ob_narrow[c*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
      else if (elem < SAT_MIN) ob_narrow[c*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
      else                     ob_narrow[c*OUT_WIDTH +: OUT_WIDTH] = elem[OUT_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    ob_narrow = '0;
    for (int c = 0; c < COL; c++) begin
      ob_narrow[c*OUT_WIDTH +: OUT_WIDTH] = sum_q[c*ACC_WIDTH +: OUT_WIDTH];
    end
  end
`endif

  // Outputs: strobes decode from state and pipe flags; addresses and data
  // are forced to zero whenever their strobe is inactive.
  always_comb begin
    ib_rd = (state_q == STREAM) && (cnt_q != '0);
    ps_rd = pipe_valid_q[LAT-2] & ~pipe_first_q[LAT-2];
    ps_wr = wr_valid_q & ~wr_last_q;
    ob_wr = wr_valid_q & wr_last_q;

    busy_o = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
    done_o = (state_q == DONE);

    wb_cenb_o = ~(state_q == LOAD_W);
    wb_addr_o = (state_q == LOAD_W) ? (WAW'(t_q) * WAW'(ROW) + WAW'(cnt_q)) : '0;
    ib_cenb_o = ~ib_rd;
    ib_addr_o = ib_rd ? (IAW'(t_q) * IAW'(m_q) + IAW'(cnt_q - CW'(1))) : '0;

    arr_mode_o   = mode_q;
    arr_wvalid_o = wvalid_q;
    arr_weight_o = wvalid_q ? wb_data_i : '0;
    arr_avalid_o = avalid_q;
    arr_act_o    = avalid_q ? ib_data_i : '0;

    ps_rd_cenb_o = ~ps_rd;
    ps_rd_addr_o = ps_rd ? PAW'(pipe_m_q[LAT-2]) : '0;
    ps_wr_cenb_o = ~ps_wr;
    ps_wr_addr_o = ps_wr ? PAW'(wr_m_q) : '0;
    ps_wr_data_o = ps_wr ? sum_q : '0;
    ob_cenb_o    = ~ob_wr;
    ob_addr_o    = ob_wr ? OAW'(wr_m_q) : '0;
    ob_data_o    = ob_wr ? ob_narrow : '0;
  end

endmodule

// File: tb/tb_matmul_tile_engine.sv
// ---------------------------------------------------------------------------
// tb_matmul_tile_engine
//
// Directed bench for matmul_tile_engine. Provides behavioural weight,
// activation, partial-sum and output buffers plus a latency-accurate model of
// the systolic array, then runs hand-computed matrix cases.
// ---------------------------------------------------------------------------
module tb_matmul_tile_engine;

  localparam int WIDTH  = 8;
  localparam int ACC    = 24;
  localparam int OW     = 8;
  localparam int ROW    = 4;
  localparam int COL    = 4;
  localparam int LAT    = 6;
  localparam int I_SIZE = 256;
  localparam int W_SIZE = 256;
  localparam int P_SIZE = 64;
  localparam int O_SIZE = 64;
  localparam int MAX_K  = 16;
  localparam int MAX_M  = 64;
  localparam int KW     = $clog2(MAX_K+1);
  localparam int MW     = $clog2(MAX_M+1);

  logic                         clk_i;
  logic                         rstn_i;
  logic                         start_i;
  logic [KW-1:0]                k_tiles_i;
  logic [MW-1:0]                m_rows_i;
  logic                         busy_o;
  logic                         done_o;
  logic                         wb_cenb_o;
  logic [$clog2(W_SIZE)-1:0]    wb_addr_o;
  logic [COL*WIDTH-1:0]         wb_data_i;
  logic                         ib_cenb_o;
  logic [$clog2(I_SIZE)-1:0]    ib_addr_o;
  logic [ROW*WIDTH-1:0]         ib_data_i;
  logic                         arr_mode_o;
  logic                         arr_wvalid_o;
  logic [COL*WIDTH-1:0]         arr_weight_o;
  logic                         arr_avalid_o;
  logic [ROW*WIDTH-1:0]         arr_act_o;
  logic [COL*ACC-1:0]           arr_psum_i;
  logic                         ps_rd_cenb_o;
  logic [$clog2(P_SIZE)-1:0]    ps_rd_addr_o;
  logic [COL*ACC-1:0]           ps_rd_data_i;
  logic                         ps_wr_cenb_o;
  logic [$clog2(P_SIZE)-1:0]    ps_wr_addr_o;
  logic [COL*ACC-1:0]           ps_wr_data_o;
  logic                         ob_cenb_o;
  logic [$clog2(O_SIZE)-1:0]    ob_addr_o;
  logic [COL*OW-1:0]            ob_data_o;

  matmul_tile_engine #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC), .OUT_WIDTH(OW), .ROW(ROW), .COL(COL),
    .ARRAY_LAT(LAT), .I_SIZE(I_SIZE), .W_SIZE(W_SIZE), .P_SIZE(P_SIZE),
    .O_SIZE(O_SIZE), .MAX_K(MAX_K), .MAX_M(MAX_M)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
    .k_tiles_i(k_tiles_i), .m_rows_i(m_rows_i),
    .busy_o(busy_o), .done_o(done_o),
    .wb_cenb_o(wb_cenb_o), .wb_addr_o(wb_addr_o), .wb_data_i(wb_data_i),
    .ib_cenb_o(ib_cenb_o), .ib_addr_o(ib_addr_o), .ib_data_i(ib_data_i),
    .arr_mode_o(arr_mode_o), .arr_wvalid_o(arr_wvalid_o),
    .arr_weight_o(arr_weight_o), .arr_avalid_o(arr_avalid_o),
    .arr_act_o(arr_act_o), .arr_psum_i(arr_psum_i),
    .ps_rd_cenb_o(ps_rd_cenb_o), .ps_rd_addr_o(ps_rd_addr_o),
    .ps_rd_data_i(ps_rd_data_i),
    .ps_wr_cenb_o(ps_wr_cenb_o), .ps_wr_addr_o(ps_wr_addr_o),
    .ps_wr_data_o(ps_wr_data_o),
    .ob_cenb_o(ob_cenb_o), .ob_addr_o(ob_addr_o), .ob_data_o(ob_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [COL*WIDTH-1:0] wb_mem [W_SIZE];
  logic [ROW*WIDTH-1:0] ib_mem [I_SIZE];
  logic [COL*ACC-1:0]   ps_mem [P_SIZE];
  logic [COL*OW-1:0]    ob_mem [O_SIZE];

  int checks;
  int errors;
  int cycle_cnt;
  int ps_wr_cnt;
  int ob_wr_cnt;
  int access_cnt;
  int busy_rise_cnt;
  int last_ob_cycle;
  int done_rise_cycle;
  logic busy_prev;
  logic done_prev;

  // Buffer models with one-cycle read latency, plus activity counters.
  always @(posedge clk_i) begin
    if (!wb_cenb_o)    wb_data_i    <= wb_mem[wb_addr_o];
    if (!ib_cenb_o)    ib_data_i    <= ib_mem[ib_addr_o];
    if (!ps_rd_cenb_o) ps_rd_data_i <= ps_mem[ps_rd_addr_o];
    if (!ps_wr_cenb_o) ps_mem[ps_wr_addr_o] <= ps_wr_data_o;
    if (!ob_cenb_o)    ob_mem[ob_addr_o]    <= ob_data_o;
    cycle_cnt <= cycle_cnt + 1;
    if (!ps_wr_cenb_o) ps_wr_cnt <= ps_wr_cnt + 1;
    if (!ob_cenb_o) begin
      ob_wr_cnt     <= ob_wr_cnt + 1;
      last_ob_cycle <= cycle_cnt;
    end
    if (!wb_cenb_o || !ib_cenb_o || !ps_rd_cenb_o || !ps_wr_cenb_o || !ob_cenb_o)
      access_cnt <= access_cnt + 1;
    if (busy_o && !busy_prev) busy_rise_cnt <= busy_rise_cnt + 1;
    if (done_o && !done_prev) done_rise_cycle <= cycle_cnt;
    busy_prev <= busy_o;
    done_prev <= done_o;
  end

  // Systolic array model: weight rows latched in arrival order, each
  // activation row's column sums appear LAT cycles after its valid.
  logic [COL*WIDTH-1:0] wreg [ROW];
  logic [COL*ACC-1:0]   sr [LAT];
  int widx;

  function automatic logic [COL*ACC-1:0] arrMac(input logic [ROW*WIDTH-1:0] act);
    logic [COL*ACC-1:0] res;
    int s;
    res = '0;
    for (int c = 0; c < COL; c++) begin
      s = 0;
      for (int r = 0; r < ROW; r++)
        s += int'($signed(act[r*WIDTH +: WIDTH])) * int'($signed(wreg[r][c*WIDTH +: WIDTH]));
      res[c*ACC +: ACC] = s[ACC-1:0];
    end
    return res;
  endfunction

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      widx <= 0;
      for (int i = 0; i < LAT; i++) sr[i] <= '0;
      for (int i = 0; i < ROW; i++) wreg[i] <= '0;
    end else begin
      if (arr_wvalid_o) begin
        wreg[widx] <= arr_weight_o;
        widx <= (widx + 1) % ROW;
      end
      sr[0] <= arr_avalid_o ? arrMac(arr_act_o) : '0;
      for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
    end
  end
  assign arr_psum_i = sr[LAT-1];

  initial begin
    checks = 0; errors = 0; cycle_cnt = 0; ps_wr_cnt = 0; ob_wr_cnt = 0;
    access_cnt = 0; busy_rise_cnt = 0; last_ob_cycle = 0; done_rise_cycle = 0;
    busy_prev = 1'b0; done_prev = 1'b0;
    wb_data_i = '0; ib_data_i = '0; ps_rd_data_i = '0;
    for (int i = 0; i < P_SIZE; i++) ps_mem[i] = '0;
    for (int i = 0; i < O_SIZE; i++) ob_mem[i] = '0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Launch a run and wait (bounded) for done; start stays high afterwards.
  task automatic applyStimulus(input int k, input int m);
    @(negedge clk_i);
    k_tiles_i = KW'(k);
    m_rows_i  = MW'(m);
    start_i   = 1'b1;
    for (int i = 0; i < 3000 && !done_o; i++) @(negedge clk_i);
    checkOutput("run_done", 64'(done_o), 64'(1));
    @(negedge clk_i);
  endtask

  task automatic releaseStart();
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic clearMems();
    for (int i = 0; i < W_SIZE; i++) wb_mem[i] = '0;
    for (int i = 0; i < I_SIZE; i++) ib_mem[i] = '0;
  endtask

  task automatic fillOnes(input int nw, input int ni);
    clearMems();
    for (int i = 0; i < nw; i++) wb_mem[i] = {COL{8'h01}};
    for (int i = 0; i < ni; i++) ib_mem[i] = {ROW{8'h01}};
  endtask

  initial begin
    logic [COL*WIDTH-1:0] wrow;
    logic [ROW*WIDTH-1:0] arow;
    logic [COL*OW-1:0]    erow;
    int ps0, ob0, acc0, busy0;

    rstn_i = 1'b0; start_i = 1'b0; k_tiles_i = '0; m_rows_i = '0;
    clearMems();
    repeat (3) @(negedge clk_i);

    // Reset state
    checkOutput("rst_cenb", 64'({wb_cenb_o, ib_cenb_o, ps_rd_cenb_o, ps_wr_cenb_o, ob_cenb_o}), 64'(5'b11111));
    checkOutput("rst_busy_done", 64'({busy_o, done_o}), 64'(2'b00));
    checkOutput("rst_arr", 64'({arr_mode_o, arr_wvalid_o, arr_avalid_o}), 64'(3'b000));
    checkOutput("rst_addr", 64'({wb_addr_o, ib_addr_o, ob_addr_o}), 64'(0));
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // K=1, M=4, identity weights: outputs equal activation rows
    $display("[TB] identity single tile");
    clearMems();
    for (int r = 0; r < ROW; r++) begin
      wrow = '0;
      wrow[r*WIDTH +: WIDTH] = 8'd1;
      wb_mem[r] = wrow;
    end
    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < ROW; r++) arow[r*WIDTH +: WIDTH] = 8'(4*m + r + 1);
      ib_mem[m] = arow;
    end
    ps0 = ps_wr_cnt; ob0 = ob_wr_cnt; busy0 = busy_rise_cnt;
    applyStimulus(1, 4);
    for (int m = 0; m < 4; m++) begin
      for (int c = 0; c < COL; c++) erow[c*OW +: OW] = 8'(4*m + c + 1);
      checkOutput($sformatf("id_ob%0d", m), 64'(ob_mem[m]), 64'(erow));
    end
    checkOutput("id_ps_writes", 64'(ps_wr_cnt - ps0), 64'(0));
    checkOutput("id_ob_writes", 64'(ob_wr_cnt - ob0), 64'(4));
    checkOutput("id_done_lat", 64'(done_rise_cycle - last_ob_cycle), 64'(1));
    checkOutput("id_busy_runs", 64'(busy_rise_cnt - busy0), 64'(1));
    checkOutput("id_busy_end", 64'(busy_o), 64'(0));
    releaseStart();
    checkOutput("id_idle_done", 64'(done_o), 64'(0));

    // K=3, M=2, all ones: each element 3*4 = 12
    $display("[TB] three tiles of ones");
    fillOnes(3*ROW, 3*2);
    ps0 = ps_wr_cnt; ob0 = ob_wr_cnt;
    applyStimulus(3, 2);
    checkOutput("ones_ob0", 64'(ob_mem[0]), 64'(32'h0C0C0C0C));
    checkOutput("ones_ob1", 64'(ob_mem[1]), 64'(32'h0C0C0C0C));
    checkOutput("ones_ps_writes", 64'(ps_wr_cnt - ps0), 64'(4));
    checkOutput("ones_ob_writes", 64'(ob_wr_cnt - ob0), 64'(2));
    releaseStart();

    // K=2, M=2: row0 100+100 = 200, row1 -100-100 = -200
    $display("[TB] narrowing");
    clearMems();
    wb_mem[0] = {COL{8'd10}};
    wb_mem[4] = {COL{8'd10}};
    ib_mem[0] = 32'h0000000A;
    ib_mem[1] = 32'h000000F6;
    ib_mem[2] = 32'h0000000A;
    ib_mem[3] = 32'h000000F6;
    ps0 = ps_wr_cnt; ob0 = ob_wr_cnt;
    applyStimulus(2, 2);
`ifdef SATURATE_EN
    checkOutput("sat_pos", 64'(ob_mem[0]), 64'(32'h7F7F7F7F));
    checkOutput("sat_neg", 64'(ob_mem[1]), 64'(32'h80808080));
`else
    checkOutput("wrap_pos", 64'(ob_mem[0]), 64'(32'hC8C8C8C8));
    checkOutput("wrap_neg", 64'(ob_mem[1]), 64'(32'h38383838));
`endif
    checkOutput("narrow_ps_writes", 64'(ps_wr_cnt - ps0), 64'(2));
    checkOutput("narrow_ob_writes", 64'(ob_wr_cnt - ob0), 64'(2));
    releaseStart();

    // Empty runs: done next cycle, no memory access
    $display("[TB] empty runs");
    acc0 = access_cnt;
    @(negedge clk_i);
    k_tiles_i = KW'(0); m_rows_i = MW'(3); start_i = 1'b1;
    @(negedge clk_i);
    checkOutput("k0_done", 64'({done_o, busy_o}), 64'(2'b10));
    releaseStart();
    @(negedge clk_i);
    k_tiles_i = KW'(2); m_rows_i = MW'(0); start_i = 1'b1;
    @(negedge clk_i);
    checkOutput("m0_done", 64'({done_o, busy_o}), 64'(2'b10));
    releaseStart();
    checkOutput("empty_access", 64'(access_cnt - acc0), 64'(0));

    // Reset during STREAM of tile 1, then a fresh single-tile run
    $display("[TB] reset mid-run");
    fillOnes(2*ROW, 2*2);
    @(negedge clk_i);
    k_tiles_i = KW'(2); m_rows_i = MW'(2); start_i = 1'b1;
    begin
      int n;
      for (n = 0; n < 500 && !(!ib_cenb_o && ib_addr_o == 8'd2); n++) @(negedge clk_i);
      checkOutput("abort_reached", 64'(n < 500), 64'(1));
    end
    rstn_i = 1'b0;
    #1;
    checkOutput("abort_cenb", 64'({wb_cenb_o, ib_cenb_o, ps_rd_cenb_o, ps_wr_cenb_o, ob_cenb_o}), 64'(5'b11111));
    checkOutput("abort_state", 64'({busy_o, done_o, arr_mode_o, arr_avalid_o, arr_wvalid_o}), 64'(0));
    checkOutput("abort_addr", 64'({ib_addr_o, wb_addr_o}), 64'(0));
    acc0 = access_cnt;
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    checkOutput("abort_quiet", 64'(access_cnt - acc0), 64'(0));
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    ps0 = ps_wr_cnt; ob0 = ob_wr_cnt;
    applyStimulus(1, 2);
    checkOutput("fresh_ob0", 64'(ob_mem[0]), 64'(32'h04040404));
    checkOutput("fresh_ob1", 64'(ob_mem[1]), 64'(32'h04040404));
    checkOutput("fresh_ps_writes", 64'(ps_wr_cnt - ps0), 64'(0));
    checkOutput("fresh_ob_writes", 64'(ob_wr_cnt - ob0), 64'(2));
    releaseStart();

    // Start pulsed while busy and held after done: only one run
    $display("[TB] start handshake");
    fillOnes(ROW, 1);
    busy0 = busy_rise_cnt;
    @(negedge clk_i);
    k_tiles_i = KW'(1); m_rows_i = MW'(1); start_i = 1'b1;
    repeat (3) @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    for (int i = 0; i < 500 && !done_o; i++) @(negedge clk_i);
    repeat (20) @(negedge clk_i);
    checkOutput("hold_done", 64'({done_o, busy_o}), 64'(2'b10));
    checkOutput("hold_runs", 64'(busy_rise_cnt - busy0), 64'(1));
    checkOutput("hold_ob0", 64'(ob_mem[0]), 64'(32'h04040404));
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("hold_release", 64'(done_o), 64'(0));
    repeat (5) @(negedge clk_i);
    checkOutput("hold_no_rerun", 64'(busy_rise_cnt - busy0), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
